// File: rtl/karatsuba_arbiter.sv
// karatsuba_arbiter: two-port round-robin front end for an iterative
// Karatsuba multiplier. One request is granted in IDLE, the multiplier is
// cleared for one cycle (CLR), enabled for LAT cycles (RUN), and the captured
// product is presented to the owning requester until it is taken (RESP).
// Optional build macro: KARATSUBA_CHECK_EN adds a full-width reference
// product compared against mul_c on the capture edge; a mismatch sets the
// sticky err flag. Without the macro err is tied low.
module karatsuba_arbiter #(
  parameter int N   = 32,
  parameter int LAT = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [N-1:0]   req_a0,
  input  logic [N-1:0]   req_b0,
  input  logic [N-1:0]   req_a1,
  input  logic [N-1:0]   req_b1,
  output logic [1:0]     resp_valid,
  input  logic [1:0]     resp_ready,
  output logic [2*N-1:0] resp_data,
  output logic           mul_rst,
  output logic           mul_enable,
  output logic [N-1:0]   mul_a,
  output logic [N-1:0]   mul_b,
  input  logic [2*N-1:0] mul_c,
  output logic           busy,
  output logic           err
);

  typedef enum logic [1:0] {IDLE, CLR, RUN, RESP} state_t;

  localparam int            CW       = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ptr_q, ptr_d;
  logic             owner_q, owner_d;
  logic [N-1:0]     opa_q, opa_d;
  logic [N-1:0]     opb_q, opb_d;
  logic [2*N-1:0]   result_q, result_d;

  logic             grant_vld;
  logic             grant_sel;
  logic             resp_hs;

`ifdef KARATSUBA_CHECK_EN
  logic             err_q, err_d;

  // Reference product at full 2N-bit width; operands are unsigned.
  function automatic logic [2*N-1:0] full_mul(input logic [N-1:0] a,
                                              input logic [N-1:0] b);
    return {{N{1'b0}}, a} * {{N{1'b0}}, b};
  endfunction
`endif

  // Arbitration: pointer breaks ties, a lone requester always wins.
  always_comb begin
    grant_vld = (state_q == IDLE) && (req_valid != 2'b00);
    grant_sel = (req_valid == 2'b11) ? ptr_q : req_valid[1];
    resp_hs   = (state_q == RESP) && resp_ready[owner_q];
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ptr_q    <= 1'b0;
      owner_q  <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
`ifdef KARATSUBA_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
`ifdef KARATSUBA_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

  // Next-state and datapath update: operands latch on accept and stay put
  // until the response is taken; mul_c is captured on the last RUN edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
`ifdef KARATSUBA_CHECK_EN
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          owner_d = grant_sel;
          opa_d   = grant_sel ? req_a1 : req_a0;
          opb_d   = grant_sel ? req_b1 : req_b0;
          state_d = CLR;
        end
      end
      CLR: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          result_d = mul_c;
`ifdef KARATSUBA_CHECK_EN
          err_d    = err_q | (mul_c != full_mul(opa_q, opb_q));
`endif
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (resp_hs) begin
          ptr_d   = ~owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; grant and multiplier clear also follow rst.
  always_comb begin
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    resp_data  = '0;
    if (grant_vld && rst) begin
      req_ready = grant_sel ? 2'b10 : 2'b01;
    end
    if (state_q == RESP) begin
      resp_valid = owner_q ? 2'b10 : 2'b01;
      resp_data  = result_q;
    end
    mul_rst    = !rst || (state_q == CLR);
    mul_enable = (state_q == RUN);
    busy       = (state_q != IDLE);
  end

  assign mul_a = opa_q;
  assign mul_b = opb_q;

`ifdef KARATSUBA_CHECK_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_karatsuba_arbiter.sv
// Directed bench for karatsuba_arbiter. The external multiplier is modelled
// as a block that only presents the true product once it has been cleared
// and enabled for LAT-1 full cycles; before that it shows a junk pattern.
module tb_karatsuba_arbiter;
  localparam int N   = 32;
  localparam int LAT = 8;

`ifdef KARATSUBA_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [1:0]     req_valid = 2'b00;
  logic [1:0]     req_ready;
  logic [N-1:0]   req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic [1:0]     resp_valid;
  logic [1:0]     resp_ready = 2'b00;
  logic [2*N-1:0] resp_data;
  logic           mul_rst, mul_enable;
  logic [N-1:0]   mul_a, mul_b;
  logic [2*N-1:0] mul_c;
  logic           busy, err;

  logic           fault = 1'b0;
  int             mcnt = 0;
  int             checks = 0;
  int             errors = 0;

  always #5 clk = ~clk;

  karatsuba_arbiter #(.N(N), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .mul_rst(mul_rst), .mul_enable(mul_enable), .mul_a(mul_a), .mul_b(mul_b),
    .mul_c(mul_c), .busy(busy), .err(err)
  );

  // Multiplier model: counts enabled cycles since the last clear.
  always @(posedge clk) begin
    if (mul_rst) mcnt <= 0;
    else if (mul_enable) mcnt <= mcnt + 1;
  end

  always_comb begin
    if (fault) mul_c = '0;
    else if (mcnt == LAT - 1) mul_c = {{N{1'b0}}, mul_a} * {{N{1'b0}}, mul_b};
    else mul_c = 64'hBAD0_BAD0_BAD0_BAD0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the cycle after accept (cycle 1); returns the cycle index at
  // which resp_valid matching mask is first seen, bounded at 60.
  task automatic wait_resp(input logic [1:0] mask, output int cyc);
    cyc = 1;
    while (((resp_valid & mask) == 2'b00) && cyc < 60) begin
      tick();
      cyc++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = 2'b00;
    resp_ready = 2'b00;
    fault = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    req_a0 = 32'd1; req_b0 = 32'd2; req_a1 = 32'd3; req_b1 = 32'd4;
    #3;
    rst = 1'b0;
    req_valid = 2'b11;
    resp_ready = 2'b11;
    #2;
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready got %b want 00", req_ready); end
    checks++;
    if (resp_valid !== 2'b00) begin errors++; $display("FAIL rst_resp_valid got %b want 00", resp_valid); end
    checks++;
    if (resp_data !== 64'd0) begin errors++; $display("FAIL rst_resp_data got %0h want 0", resp_data); end
    checks++;
    if ({mul_rst, mul_enable, busy, err} !== 4'b1000) begin
      errors++; $display("FAIL rst_ctrl {mul_rst,mul_enable,busy,err} got %b want 1000", {mul_rst, mul_enable, busy, err});
    end
    tick();
    tick();
    checks++;
    if ({mul_a, mul_b} !== 64'd0) begin errors++; $display("FAIL rst_mul_ops got %0h want 0", {mul_a, mul_b}); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_held_busy got %b want 0", busy); end
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL release_no_accept busy got %b want 0", busy); end
    req_valid = 2'b00;
    resp_ready = 2'b00;
    tick();
  endtask

  task automatic test_single();
    int cyc, en_cnt;
    logic seen1;
    req_a0 = 32'd10; req_b0 = 32'd12;
    req_valid = 2'b01;
    resp_ready = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL single_grant got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    checks++;
    if ({busy, mul_rst, mul_enable} !== 3'b110) begin
      errors++; $display("FAIL single_clr {busy,mul_rst,mul_enable} got %b want 110", {busy, mul_rst, mul_enable});
    end
    checks++;
    if (mul_a !== 32'd10 || mul_b !== 32'd12) begin
      errors++; $display("FAIL single_ops got %0d,%0d want 10,12", mul_a, mul_b);
    end
    cyc = 1; en_cnt = 0; seen1 = 1'b0;
    while (resp_valid[0] !== 1'b1 && cyc < 60) begin
      if (req_ready[1]) seen1 = 1'b1;
      if (mul_enable) en_cnt++;
      tick();
      cyc++;
    end
    checks++;
    if (cyc != LAT + 2) begin errors++; $display("FAIL single_latency got %0d want %0d", cyc, LAT + 2); end
    checks++;
    if (en_cnt != LAT) begin errors++; $display("FAIL single_enable_cycles got %0d want %0d", en_cnt, LAT); end
    checks++;
    if (resp_valid !== 2'b01 || resp_data !== 64'd120) begin
      errors++; $display("FAIL single_resp got %b/%0d want 01/120", resp_valid, resp_data);
    end
    checks++;
    if (seen1 !== 1'b0) begin errors++; $display("FAIL single_ready1 got 1 want 0"); end
    tick();
    checks++;
    if (busy !== 1'b0 || resp_valid !== 2'b00 || resp_data !== 64'd0) begin
      errors++; $display("FAIL single_idle busy/valid/data got %b/%b/%0d want 0/00/0", busy, resp_valid, resp_data);
    end
  endtask

  task automatic test_simultaneous();
    int cyc;
    do_reset();
    req_a0 = 32'd255;   req_b0 = 32'd255;
    req_a1 = 32'd65535; req_b1 = 32'd2;
    req_valid = 2'b11;
    resp_ready = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL simul_grant0 got %b want 01", req_ready); end
    tick();
    req_valid = 2'b10;
    wait_resp(2'b01, cyc);
    checks++;
    if (cyc != LAT + 2 || resp_data !== 64'd65025 || resp_valid !== 2'b01) begin
      errors++; $display("FAIL simul_resp0 got cyc %0d %b/%0d want %0d 01/65025", cyc, resp_valid, resp_data, LAT + 2);
    end
    tick();
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL simul_grant1 got %b want 10", req_ready); end
    tick();
    req_valid = 2'b00;
    checks++;
    if (mul_a !== 32'd65535 || mul_b !== 32'd2) begin
      errors++; $display("FAIL simul_ops1 got %0d,%0d want 65535,2", mul_a, mul_b);
    end
    wait_resp(2'b10, cyc);
    checks++;
    if (cyc != LAT + 2 || resp_data !== 64'd131070 || resp_valid !== 2'b10) begin
      errors++; $display("FAIL simul_resp1 got cyc %0d %b/%0d want %0d 10/131070", cyc, resp_valid, resp_data, LAT + 2);
    end
    tick();
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL simul_ptr_back got %b want 01", req_ready); end
    req_valid = 2'b00;
    #1;
  endtask

  task automatic test_backpressure();
    int cyc;
    logic ok;
    req_a0 = 32'hFFFF_FFFF; req_b0 = 32'd255;
    req_valid = 2'b01;
    resp_ready = 2'b00;
    tick();
    req_valid = 2'b00;
    wait_resp(2'b01, cyc);
    checks++;
    if (cyc != LAT + 2 || resp_data !== 64'd1095216660225) begin
      errors++; $display("FAIL bp_first got cyc %0d data %0d want %0d 1095216660225", cyc, resp_data, LAT + 2);
    end
    resp_ready = 2'b10;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (resp_valid !== 2'b01 || resp_data !== 64'd1095216660225 ||
          mul_a !== 32'hFFFF_FFFF || mul_b !== 32'd255) ok = 1'b0;
    end
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL bp_hold got unstable want stable"); end
    resp_ready = 2'b01;
    tick();
    checks++;
    if (busy !== 1'b0 || resp_valid !== 2'b00) begin
      errors++; $display("FAIL bp_idle busy/valid got %b/%b want 0/00", busy, resp_valid);
    end
    req_a0 = 32'd2; req_b0 = 32'd3;
    req_valid = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_next_grant got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL bp_next_accept busy got %b want 1", busy); end
    wait_resp(2'b01, cyc);
    checks++;
    if (resp_data !== 64'd6) begin errors++; $display("FAIL bp_next_data got %0d want 6", resp_data); end
    tick();
  endtask

  task automatic test_reset_mid_run();
    logic seen;
    req_a1 = 32'd7; req_b1 = 32'd9;
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (mul_enable !== 1'b1) begin errors++; $display("FAIL mid_run_state mul_enable got %b want 1", mul_enable); end
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, mul_enable, mul_rst} !== 3'b001 || {mul_a, mul_b} !== 64'd0) begin
      errors++; $display("FAIL mid_rst_ctrl got %b ops %0h want 001 ops 0", {busy, mul_enable, mul_rst}, {mul_a, mul_b});
    end
    checks++;
    if (resp_valid !== 2'b00 || resp_data !== 64'd0 || req_ready !== 2'b00) begin
      errors++; $display("FAIL mid_rst_resp got %b/%0d/%b want 00/0/00", resp_valid, resp_data, req_ready);
    end
    tick();
    rst = 1'b1;
    resp_ready = 2'b11;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (resp_valid !== 2'b00 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL mid_rst_no_resp got activity want none"); end
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_rst_ptr got %b want 01", req_ready); end
    req_valid = 2'b00;
    #1;
  endtask

  task automatic test_sweep();
    int cyc, a, b;
    logic [1:0] mask;
    logic [63:0] expv;
    resp_ready = 2'b11;
    for (int i = 0; i < 256; i++) begin
      a = i;
      b = (i * 73 + 5) % 256;
      if (i == 254) b = 255;
      expv = 64'(a * b);
      mask = (i % 2 == 1) ? 2'b10 : 2'b01;
      if (mask[1]) begin req_a1 = 32'(a); req_b1 = 32'(b); end
      else begin req_a0 = 32'(a); req_b0 = 32'(b); end
      req_valid = mask;
      tick();
      req_valid = 2'b00;
      wait_resp(mask, cyc);
      checks++;
      if (resp_data !== expv || resp_valid !== mask) begin
        errors++; $display("FAIL sweep %0dx%0d got %b/%0d want %b/%0d", a, b, resp_valid, resp_data, mask, expv);
      end
      tick();
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL sweep_err got %b want 0", err); end
  endtask

  task automatic test_fault();
    int cyc;
    req_a0 = 32'd3; req_b0 = 32'd5;
    fault = 1'b1;
    req_valid = 2'b01;
    resp_ready = 2'b00;
    tick();
    req_valid = 2'b00;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL fault_pre_err got %b want 0", err); end
    wait_resp(2'b01, cyc);
    checks++;
    if (resp_data !== 64'd0) begin errors++; $display("FAIL fault_data got %0d want 0", resp_data); end
    checks++;
    if (err !== ERR_EXP) begin errors++; $display("FAIL fault_err got %b want %b", err, ERR_EXP); end
    resp_ready = 2'b01;
    tick();
    fault = 1'b0;
    req_a0 = 32'd2; req_b0 = 32'd2;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    wait_resp(2'b01, cyc);
    checks++;
    if (resp_data !== 64'd4 || err !== ERR_EXP) begin
      errors++; $display("FAIL fault_sticky data/err got %0d/%b want 4/%b", resp_data, err, ERR_EXP);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL fault_clear got %b want 0", err); end
    tick();
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_reset_mid_run();
    test_sweep();
    test_fault();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
